// File: rtl/mult8_sequencer.sv
// Control FSM for the signed shift-add multiplier: WIDTH add/shift iterations, subtract on the last.
// Optional MULT8_CLEAR_ON_RUN_EN adds a one-cycle CLR state that clears A/X on every start.
module mult8_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic Clear_AX,
  output logic Add,
  output logic Sub,
  output logic Shift,
  output logic Busy,
  output logic Done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef MULT8_CLEAR_ON_RUN_EN
  typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, HOLD} state_t;
`endif

  state_t          state, next_state;
  logic [CW-1:0]   count, count_next;

  // State and iteration counter; reset wins over everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      count <= count_next;
    end
  end

  // Next-state and datapath strobe decode.
  always_comb begin
    next_state = state;
    count_next = count;
    Clr_Ld     = 1'b0;
    Clear_AX   = 1'b0;
    Add        = 1'b0;
    Sub        = 1'b0;
    Shift      = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        Clr_Ld = ClearA_LoadB;
        if (!ClearA_LoadB && Run) begin
          count_next = '0;
`ifdef MULT8_CLEAR_ON_RUN_EN
          next_state = CLR;
`else
          next_state = ADD;
`endif
        end
      end
`ifdef MULT8_CLEAR_ON_RUN_EN
      CLR: begin
        Busy       = 1'b1;
        Clear_AX   = 1'b1;
        next_state = ADD;
      end
`endif
      ADD: begin
        Busy = 1'b1;
        // Sign bit of B carries negative weight, hence subtract on the last iteration.
        if (M) begin
          if (count == LAST) Sub = 1'b1;
          else               Add = 1'b1;
        end
        next_state = SHIFT;
      end
      SHIFT: begin
        Busy  = 1'b1;
        Shift = 1'b1;
        if (count == LAST) begin
          next_state = HOLD;
        end else begin
          count_next = count + CW'(1);
          next_state = ADD;
        end
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
